regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (we3/wa3/wd3) between the pipeline writeback stage and the long-latency multiply/divide unit. Writeback always has priority. Mul/div results queue in a small FIFO and drain on free cycles, with a starvation guard that forces a drain slot. A pending-write scoreboard flags decode-stage reads of registers whose mul/div result has not yet been written.

Parameters:
DEPTH, 2, mul/div result FIFO entries (power of two, >=2)
STARVE_MAX, 4, consecutive blocked cycles with FIFO non-empty before wb_stall asserts (>=1)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high
wb_we  in  1  writeback stage write request
wb_wa  in  5  writeback destination register
wb_wd  in  32  writeback data
md_valid  in  1  mul/div result valid
md_ready  out  1  FIFO can accept result
md_wa  in  5  mul/div destination register
md_wd  in  32  mul/div result data
md_issue  in  1  mul/div op launched this cycle (sets scoreboard)
md_issue_wa  in  5  destination of launched op
chk_ra1  in  5  decode read address 1
chk_ra2  in  5  decode read address 2
busy1  out  1  chk_ra1 has a pending mul/div write
busy2  out  1  chk_ra2 has a pending mul/div write
wb_stall  out  1  pipeline must hold wb_we low this cycle
rf_we3  out  1  regfile write enable
rf_wa3  out  5  regfile write address
rf_wd3  out  32  regfile write data

Behaviour:
- Reset (synchronous, active-high): FIFO empty, pointers/count 0, pending[31:0]=0, starve counter 0, wb_stall=0. While reset is high, md_ready=0, rf_we3=0, busy1=busy2=0. Reset mid-operation discards queued results and clears all pending bits.
- Write-port mux (combinational, same cycle): wb_we=1 -> rf_* = {1, wb_wa, wb_wd}; else if FIFO non-empty -> rf_* = {1, head.wa, head.wd} and head pops at the clock edge; else rf_we3=0, rf_wa3=0, rf_wd3=0.
- FIFO: md_ready = !full and !reset. Accept on md_valid&&md_ready. Push and pop in the same cycle is allowed when full (pop frees a slot for the following cycle only; md_ready stays low that cycle). md_wa=0 is accepted, never enqueued, and does not touch the scoreboard.
- Scoreboard: md_issue with md_issue_wa!=0 sets pending[md_issue_wa]. A FIFO pop clears pending[head.wa]. Simultaneous set and clear of the same register leaves the bit set. busy1 = pending[chk_ra1] and busy2 = pending[chk_ra2], both combinational; register 0 is never busy. A wb write to a pending register leaves pending unchanged. The pipeline stalls on busy, so WAW is not generated.
- Starvation: counter increments each cycle where FIFO is non-empty and wb_we=1, and resets on any pop or when the FIFO is empty. When counter==STARVE_MAX, wb_stall=1 (registered) for exactly one cycle. The pipeline guarantees wb_we=0 in that cycle, so the head drains. The counter then returns to 0. If wb_we=1 while wb_stall=1 (protocol violation), wb still wins and the counter holds at STARVE_MAX.
- Ordering: FIFO drains strictly in order. Worst-case drain latency from accept to write is (entries ahead + 1) * (STARVE_MAX + 1) cycles.

Optional Feature:
MD_BYPASS_EN
- Defined: when the FIFO is empty, wb_we=0 and md_valid=1, the result goes straight to rf_* in the same cycle and is not enqueued. Its pending bit clears at that edge. md_ready is 1 in this case.
- Undefined: every accepted result is enqueued. Earliest write is the cycle after accept.

Test Plan:
- Reset then idle -> rf_we3=0, md_ready=1, busy1=busy2=0, wb_stall=0.
- md_issue wa=5, later md_valid wa=5 wd=0x1234 with wb_we=0 -> chk_ra1=5 gives busy1=1 until the write. rf_we3=1, rf_wa3=5, rf_wd3=0x1234 one cycle after accept (same cycle with MD_BYPASS_EN). busy1=0 after that edge.
- wb_we held 1 (wa=3, wd=0xAA) while the FIFO holds wa=7 -> rf_wa3=3 for 4 cycles, then wb_stall=1 for one cycle (bench drops wb_we), rf_wa3=7 written, counter cleared.
- Three md results back-to-back with wb_we=1 and DEPTH=2 -> md_ready=0 after two accepts. Third held until a pop. Writes occur in order 1,2,3.
- md_issue wa=9 in the same cycle the FIFO pops wa=9 -> pending[9] remains 1, busy on chk_ra2=9.
- Reset asserted with FIFO full and pending bits set -> next cycle FIFO empty, busy=0, no rf write of discarded entries.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between writeback and queued mul/div results,
// with a starvation guard and a pending-write scoreboard. Optional macro: MD_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_wa,
    input  logic [31:0] wb_wd,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_wa,
    input  logic [31:0] md_wd,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_wa,
    input  logic [4:0]  chk_ra1,
    input  logic [4:0]  chk_ra2,
    output logic        busy1,
    output logic        busy2,
    output logic        wb_stall,
    output logic        rf_we3,
    output logic [4:0]  rf_wa3,
    output logic [31:0] rf_wd3
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } md_ent_t;

    md_ent_t [DEPTH-1:0] mem;
    md_ent_t             head;
    logic [AW-1:0]       rd_ptr, wr_ptr;
    logic [AW:0]         count;
    logic [31:0]         pending, pend_nxt;
    logic [CW-1:0]       starve, starve_nxt;
    logic                stall_q;
    logic                empty, full, accept, push, pop, byp, byp_wr;

    assign head     = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign md_ready = !full && !reset;
    assign accept   = md_valid && md_ready;

`ifdef MD_BYPASS_EN
    // Empty queue and idle port: the result skips the FIFO entirely.
    assign byp = !reset && empty && !wb_we && md_valid;
`else
    assign byp = 1'b0;
`endif
    assign byp_wr = byp && (md_wa != 5'd0);

    // Register 0 results are absorbed without ever reaching the queue.
    assign push = accept && (md_wa != 5'd0) && !byp;
    assign pop  = !reset && !wb_we && !empty;

    always_comb begin
        rf_we3 = 1'b0;
        rf_wa3 = '0;
        rf_wd3 = '0;
        if (!reset) begin
            if (wb_we) begin
                rf_we3 = 1'b1;
                rf_wa3 = wb_wa;
                rf_wd3 = wb_wd;
            end else if (!empty) begin
                rf_we3 = 1'b1;
                rf_wa3 = head.wa;
                rf_wd3 = head.wd;
            end else if (byp_wr) begin
                rf_we3 = 1'b1;
                rf_wa3 = md_wa;
                rf_wd3 = md_wd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {md_wa, md_wd};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // A new issue to the same register outranks the retiring write.
    always_comb begin
        pend_nxt = pending;
        if (pop)    pend_nxt[head.wa] = 1'b0;
        if (byp_wr) pend_nxt[md_wa]   = 1'b0;
        if (md_issue && (md_issue_wa != 5'd0)) pend_nxt[md_issue_wa] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) pending <= '0;
        else       pending <= pend_nxt;
    end

    assign busy1 = !reset && pending[chk_ra1];
    assign busy2 = !reset && pending[chk_ra2];

    // Non-empty and not popping means writeback took the port.
    always_comb begin
        starve_nxt = starve;
        if (pop || empty)
            starve_nxt = '0;
        else if (wb_we && (starve != CW'(STARVE_MAX)))
            starve_nxt = starve + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve  <= '0;
            stall_q <= 1'b0;
        end else begin
            starve  <= starve_nxt;
            stall_q <= (starve_nxt == CW'(STARVE_MAX));
        end
    end

    assign wb_stall = stall_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: queue/scoreboard model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_regfile_wb_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we, md_valid, md_issue;
    logic [4:0]  wb_wa, md_wa, md_issue_wa, chk_ra1, chk_ra2;
    logic [31:0] wb_wd, md_wd;
    logic        md_ready, busy1, busy2, wb_stall, rf_we3;
    logic [4:0]  rf_wa3;
    logic [31:0] rf_wd3;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .md_valid(md_valid), .md_ready(md_ready), .md_wa(md_wa), .md_wd(md_wd),
        .md_issue(md_issue), .md_issue_wa(md_issue_wa),
        .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .busy1(busy1), .busy2(busy2),
        .wb_stall(wb_stall), .rf_we3(rf_we3), .rf_wa3(rf_wa3), .rf_wd3(rf_wd3)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: ordered queue of results, pending bit per register, blocked-cycle count.
    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pend = '0;
    int          m_scnt = 0;
    logic        run = 1'b0;
    logic [4:0]  wlog[$];
    logic        disc_seen = 1'b0;

    always @(negedge clk) begin
        logic        e_we, e_rdy, popm, bypm;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        if (run) begin
            e_we = 1'b0; e_wa = '0; e_wd = '0; popm = 1'b0; bypm = 1'b0;
            e_rdy = !reset && (q.size() < DEPTH);
            if (!reset) begin
                if (wb_we) begin
                    e_we = 1'b1; e_wa = wb_wa; e_wd = wb_wd;
                end else if (q.size() > 0) begin
                    e_we = 1'b1; e_wa = q[0].wa; e_wd = q[0].wd; popm = 1'b1;
                end
`ifdef MD_BYPASS_EN
                else if (md_valid) begin
                    bypm = 1'b1;
                    if (md_wa != 5'd0) begin
                        e_we = 1'b1; e_wa = md_wa; e_wd = md_wd;
                    end
                end
`endif
            end
            chk("md_ready", {31'd0, md_ready}, {31'd0, e_rdy});
            chk("rf_we3", {31'd0, rf_we3}, {31'd0, e_we});
            chk("rf_wa3", {27'd0, rf_wa3}, {27'd0, e_wa});
            chk("rf_wd3", rf_wd3, e_wd);
            chk("busy1", {31'd0, busy1}, {31'd0, !reset && m_pend[chk_ra1]});
            chk("busy2", {31'd0, busy2}, {31'd0, !reset && m_pend[chk_ra2]});
            chk("wb_stall", {31'd0, wb_stall}, {31'd0, m_scnt == STARVE_MAX});
            if (rf_we3 && (rf_wa3 inside {5'd20, 5'd21})) disc_seen = 1'b1;
            if (rf_we3 && (rf_wa3 inside {[5'd11:5'd13]})) wlog.push_back(rf_wa3);

            if (reset) begin
                q.delete();
                m_pend = '0;
                m_scnt = 0;
            end else begin
                if (popm || q.size() == 0) m_scnt = 0;
                else if (wb_we && m_scnt < STARVE_MAX) m_scnt++;
                if (popm) begin
                    m_pend[q[0].wa] = 1'b0;
                    void'(q.pop_front());
                end
                if (bypm) m_pend[md_wa] = 1'b0;
                if (md_issue && md_issue_wa != 5'd0) m_pend[md_issue_wa] = 1'b1;
                if (md_valid && e_rdy && md_wa != 5'd0 && !bypm) q.push_back({md_wa, md_wd});
            end
        end
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        wb_we = 0; wb_wa = 0; wb_wd = 0;
        md_valid = 0; md_wa = 0; md_wd = 0;
        md_issue = 0; md_issue_wa = 0;
        chk_ra1 = 0; chk_ra2 = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        reset = 1'b1;
        idle_in();
        nxt();
        run = 1'b1;
        nxt();
        reset = 1'b0;

        // Reset state then idle
        @(negedge clk);
        chk("idle_we", {31'd0, rf_we3}, 32'd0);
        chk("idle_rdy", {31'd0, md_ready}, 32'd1);
        chk("idle_busy", {30'd0, busy1, busy2}, 32'd0);
        chk("idle_stall", {31'd0, wb_stall}, 32'd0);
        nxt();

        // Issue to r5, result later; busy until written
        md_issue = 1; md_issue_wa = 5; chk_ra1 = 5;
        @(negedge clk);
        chk("busy_before_set", {31'd0, busy1}, 32'd0);
        nxt();
        md_issue = 0;
        @(negedge clk);
        chk("busy_set", {31'd0, busy1}, 32'd1);
        nxt();
        md_valid = 1; md_wa = 5; md_wd = 32'h1234;
        @(negedge clk);
`ifdef MD_BYPASS_EN
        chk("byp_we", {31'd0, rf_we3}, 32'd1);
        chk("byp_wa", {27'd0, rf_wa3}, 32'd5);
        chk("byp_wd", rf_wd3, 32'h1234);
        chk("byp_busy", {31'd0, busy1}, 32'd1);
        nxt();
        md_valid = 0;
        @(negedge clk);
        chk("byp_cleared", {31'd0, busy1}, 32'd0);
        nxt();
`else
        chk("acc_no_write", {31'd0, rf_we3}, 32'd0);
        nxt();
        md_valid = 0;
        @(negedge clk);
        chk("md_we", {31'd0, rf_we3}, 32'd1);
        chk("md_wa", {27'd0, rf_wa3}, 32'd5);
        chk("md_wd", rf_wd3, 32'h1234);
        chk("md_busy_until_edge", {31'd0, busy1}, 32'd1);
        nxt();
        @(negedge clk);
        chk("md_busy_cleared", {31'd0, busy1}, 32'd0);
        nxt();
`endif
        idle_in();

        // Starvation: wb holds the port while r7 waits
        wb_we = 1; wb_wa = 3; wb_wd = 32'hAA;
        md_valid = 1; md_wa = 7; md_wd = 32'h77;
        @(negedge clk);
        chk("starve_wb_first", {27'd0, rf_wa3}, 32'd3);
        nxt();
        md_valid = 0;
        n = 0;
        for (int i = 0; i < 12 && !wb_stall; i++) begin
            @(negedge clk);
            if (rf_we3 && rf_wa3 == 5'd3) n++;
            nxt();
        end
        chk("stall_seen", {31'd0, wb_stall}, 32'd1);
        chk("wb_cycles_before_stall", n, 32'd4);
        wb_we = 0;
        @(negedge clk);
        chk("stall_drain_wa", {27'd0, rf_wa3}, 32'd7);
        chk("stall_drain_wd", rf_wd3, 32'h77);
        nxt();
        @(negedge clk);
        chk("stall_one_cycle", {31'd0, wb_stall}, 32'd0);
        nxt();

        // Three results against a busy writeback, DEPTH=2
        k = 0;
        for (int i = 0; i < 60 && (k < 3 || wlog.size() < 3); i++) begin
            wb_we = !wb_stall; wb_wa = 3; wb_wd = 32'hAA;
            md_valid = (k < 3); md_wa = 5'(11 + k); md_wd = 32'h111 * (k + 1);
            @(negedge clk);
            if (i == 2) chk("full_not_ready", {31'd0, md_ready}, 32'd0);
            if (i == 5) begin
                chk("full_pop_stall", {31'd0, wb_stall}, 32'd1);
                chk("full_pop_not_ready", {31'd0, md_ready}, 32'd0);
            end
            if (md_valid && md_ready) k++;
            nxt();
        end
        chk("order_count", wlog.size(), 32'd3);
        if (wlog.size() == 3) begin
            chk("order_0", {27'd0, wlog[0]}, 32'd11);
            chk("order_1", {27'd0, wlog[1]}, 32'd12);
            chk("order_2", {27'd0, wlog[2]}, 32'd13);
        end
        idle_in();
        nxt();

        // Issue r9 in the same cycle r9 pops: bit stays set
        md_issue = 1; md_issue_wa = 9;
        nxt();
        md_issue = 0;
        wb_we = 1; wb_wa = 3; wb_wd = 32'hAA;
        md_valid = 1; md_wa = 9; md_wd = 32'h99;
        nxt();
        wb_we = 0; md_valid = 0;
        md_issue = 1; md_issue_wa = 9; chk_ra2 = 9;
        @(negedge clk);
        chk("sb_pop_wa", {27'd0, rf_wa3}, 32'd9);
        chk("sb_busy_pre", {31'd0, busy2}, 32'd1);
        nxt();
        md_issue = 0;
        @(negedge clk);
        chk("sb_set_wins", {31'd0, busy2}, 32'd1);
        nxt();

        // Reset with a full FIFO and pending bits
        wb_we = 1; wb_wa = 3; wb_wd = 32'hAA;
        md_issue = 1; md_issue_wa = 20; md_valid = 1; md_wa = 20; md_wd = 32'h20;
        nxt();
        md_issue_wa = 21; md_wa = 21; md_wd = 32'h21;
        nxt();
        md_issue = 0; md_valid = 0; chk_ra1 = 20; chk_ra2 = 21;
        @(negedge clk);
        chk("rst_pre_full", {31'd0, md_ready}, 32'd0);
        chk("rst_pre_busy", {30'd0, busy1, busy2}, 32'd3);
        nxt();
        reset = 1; wb_we = 0;
        @(negedge clk);
        chk("rst_we", {31'd0, rf_we3}, 32'd0);
        chk("rst_rdy", {31'd0, md_ready}, 32'd0);
        nxt();
        reset = 0; chk_ra2 = 9;
        @(negedge clk);
        chk("post_rst_we", {31'd0, rf_we3}, 32'd0);
        chk("post_rst_busy", {30'd0, busy1, busy2}, 32'd0);
        chk("post_rst_rdy", {31'd0, md_ready}, 32'd1);
        nxt();
        idle_in();
        nxt();
        nxt();
        chk("no_discarded_write", {31'd0, disc_seen}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
